uvmt_st_dut_echo: RTL
=====================

# uvmt_st_dut_echo

Self-test DUT for the Moore.io UVM Extension Library VIP self-test bench. It sits between the agent's transmit and receive ends inside the DUT wrapper. Frames arriving on the rx side are buffered store-and-forward and echoed unchanged on the tx side. The DUT wrapper's checker observes both sides, so this block is the responder end of the same ready/valid/last stream protocol.

## Interface
Parameters:
- DATA_WIDTH, 32: width of rx_data/tx_data.
- DEPTH, 16: FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- rx_valid  in  1  upstream beat valid.
- rx_ready  out  1  block can accept a beat.
- rx_data  in  DATA_WIDTH  upstream beat payload.
- rx_last  in  1  beat is the final beat of a frame.
- tx_valid  out  1  echoed beat valid.
- tx_ready  in  1  downstream accepts the beat.
- tx_data  out  DATA_WIDTH  echoed payload.
- tx_last  out  1  final beat of the echoed frame.
- frames_stored  out  $clog2(DEPTH)+1  count of complete frames held.
- err_oversize  out  1  one-cycle pulse when a frame exceeds DEPTH beats.

## Operation
- Beat accepted on rx when rx_valid && rx_ready. Beat sent on tx when tx_valid && tx_ready.
- The FIFO stores {last, data}. The word count ranges 0..DEPTH, with a DEPTH+1-state counter. Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- rx_ready = (count != DEPTH). It is not relaxed by a same-cycle pop, so there is no full pass-through.
- Controller states:
  - STORE: tx_valid = 1 only when frames_stored > 0.
  - FORWARD: tx_valid = FIFO non-empty.
- STORE → FORWARD when frames_stored > 0 at a cycle boundary, or when the FIFO is full with frames_stored == 0 (oversize frame).
- FORWARD → STORE after a tx beat with tx_last = 1, if frames_stored becomes 0 at that edge.
- Oversize entry (full, no complete frame):
  - err_oversize pulses for one cycle.
  - The frame is forwarded cut-through until its last beat leaves.
  - No data is dropped.
- frames_stored:
  - +1 on an rx beat with rx_last.
  - −1 on a tx beat with tx_last.
  - Simultaneous +1/−1 leaves it unchanged.
  - Saturation is impossible by construction.
- Protocol rules:
  - tx_valid, once high, stays high with stable tx_data/tx_last until tx_ready.
  - The block never depends on rx_valid staying high.
- Reset, asserted at any time including mid-frame:
  - Pointers, count and frames_stored go to 0; state goes to STORE.
  - rx_ready = 1, tx_valid = 0, tx_data = 0, tx_last = 0, err_oversize = 0.
  - Partial frames are discarded.

## Timing
- Store-and-forward latency: rx beat with rx_last accepted at edge N → first beat of that frame has tx_valid = 1 in cycle N+1.
- Throughput: one beat per cycle on each side, concurrently.
- tx_data/tx_last driven from the FIFO read port. They are registered (the FIFO memory is flops) and held constant while stalled.
- err_oversize asserts the cycle after the edge on which count reaches DEPTH with frames_stored == 0.
- Only combinational output paths: rx_ready and tx_valid, from registered state. There is no combinational path from input to output.

## Structure
- Package uvmt_st_dut_pkg holds:
  - state enum uvmt_st_dut_echo_state_t (STORE, FORWARD);
  - localparam default widths.
- Sub-module uvmt_st_dut_fifo: synchronous flop FIFO with push/pop, full/empty and count. It is parameterized by width and depth and is reusable by future self-test DUTs.
- Top level holds the controller FSM, the frames_stored counter and the oversize detection.

## Test plan
- Single 3-beat frame 0xA0, 0xA1, 0xA2 (last on 0xA2), tx_ready = 1:
  - tx_valid first high the cycle after the 0xA2 accept;
  - 0xA0..0xA2 echoed back-to-back with tx_last only on 0xA2;
  - frames_stored goes 0→1→0.
- Backpressure: tx_ready = 0, send 16 single-beat frames:
  - rx_ready drops after the 16th accept; frames_stored = 16;
  - raising tx_ready drains 16 beats in order, and rx_ready returns after the first pop.
- Oversize: 20-beat frame with DEPTH = 16, tx_ready = 1 only after fill:
  - err_oversize pulses once;
  - all 20 beats echoed in order, tx_last on beat 20; state returns to STORE.
- Simultaneous traffic: alternate 1-beat and 2-beat frames, random rx_valid/tx_ready at 50%:
  - echoed stream equals the input stream beat-for-beat;
  - tx_data is stable during stalls.
- Reset mid-frame: assert reset_n low after 2 beats of a 4-beat frame:
  - outputs go immediately to reset values (rx_ready = 1, tx_valid = 0, frames_stored = 0);
  - a following frame 0x55 (last) echoes alone.
- Wrap-around: 40 single-beat frames with increasing data at full rate:
  - pointers wrap twice with no loss or reorder.

Source files
------------

// File: rtl/uvmt_st_dut_pkg.sv
// Shared types and default sizes for the self-test DUT blocks.
package uvmt_st_dut_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 16;

  typedef enum logic {
    STORE   = 1'b0,
    FORWARD = 1'b1
  } uvmt_st_dut_echo_state_t;

endpackage

// File: rtl/uvmt_st_dut_fifo.sv
// Synchronous flop FIFO with push/pop, full/empty flags and an occupancy count.
module uvmt_st_dut_fifo
  import uvmt_st_dut_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_WIDTH + 1,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Memory is reset so the read port presents zero until the first write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uvmt_st_dut_echo.sv
// Store-and-forward echo responder: buffers whole rx frames and replays them on tx.
module uvmt_st_dut_echo
  import uvmt_st_dut_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic [DATA_WIDTH-1:0]  rx_data,
  input  logic                   rx_last,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [DATA_WIDTH-1:0]  tx_data,
  output logic                   tx_last,
  output logic [$clog2(DEPTH):0] frames_stored,
  output logic                   err_oversize
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  uvmt_st_dut_echo_state_t state;

  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_next;
  logic [CW-1:0]     frames_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [DATA_WIDTH:0] pop_word;

  assign rx_ready    = !fifo_full;
  assign tx_valid    = (state == FORWARD) ? !fifo_empty : (frames_stored != '0);
  assign push        = rx_valid && rx_ready;
  assign pop         = tx_valid && tx_ready;
  assign tx_last     = pop_word[DATA_WIDTH];
  assign tx_data     = pop_word[DATA_WIDTH-1:0];
  assign count_next  = fifo_count + CW'(push) - CW'(pop);
  assign frames_next = frames_stored + CW'(push && rx_last) - CW'(pop && tx_last);

  uvmt_st_dut_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({rx_last, rx_data}),
    .pop       (pop),
    .pop_data  (pop_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A FIFO that fills with no complete frame would deadlock, so it is drained cut-through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= STORE;
      frames_stored <= '0;
      err_oversize  <= 1'b0;
    end else begin
      frames_stored <= frames_next;
      err_oversize  <= 1'b0;
      case (state)
        STORE: begin
          if (frames_next != '0) begin
            state <= FORWARD;
          end else if (count_next == FULL_COUNT) begin
            state        <= FORWARD;
            err_oversize <= 1'b1;
          end
        end
        FORWARD: begin
          if (pop && tx_last && (frames_next == '0)) begin
            state <= STORE;
          end
        end
        default: state <= STORE;
      endcase
    end
  end

endmodule
